cp0_reg: RTL and testbench

Coprocessor-0 register file for the tinyMIPS core. It sits at the consuming end of the memory/write-back pipeline register's CP0 write channel: `wb_cp0_reg_we` / `wb_cp0_reg_write_addr` / `wb_cp0_reg_data` arrive here and commit architected state. It also:
- serves combinational reads to the execute stage;
- runs the Count/Compare timer;
- latches hardware interrupt lines;
- applies exception and ERET side effects to Status, Cause and EPC.

---
 rtl/cp0_reg.sv | 152 +++++++++++++++
 tb/tb_cp0_reg.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_reg.sv
// Coprocessor-0 register file: architected CP0 state, Count/Compare timer,
// interrupt line latch and exception/ERET side effects on Status, Cause, EPC.
module cp0_reg #(
   parameter logic [31:0] PRID_VALUE   = 32'h004c0102,
   parameter logic [31:0] CONFIG_VALUE = 32'h00008000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        we_i,
   input  logic [4:0]  waddr_i,
   input  logic [31:0] data_i,
   input  logic [4:0]  raddr_i,
   input  logic [5:0]  int_i,
   input  logic [31:0] excepttype_i,
   input  logic [31:0] current_inst_addr_i,
   input  logic        is_in_delayslot_i,
   output logic [31:0] data_o,
   output logic [31:0] count_o,
   output logic [31:0] compare_o,
   output logic [31:0] status_o,
   output logic [31:0] cause_o,
   output logic [31:0] epc_o,
   output logic [31:0] config_o,
   output logic [31:0] prid_o,
   output logic        timer_int_o
);

   localparam logic [4:0] REG_COUNT   = 5'd9;
   localparam logic [4:0] REG_COMPARE = 5'd11;
   localparam logic [4:0] REG_STATUS  = 5'd12;
   localparam logic [4:0] REG_CAUSE   = 5'd13;
   localparam logic [4:0] REG_EPC     = 5'd14;
   localparam logic [4:0] REG_PRID    = 5'd15;
   localparam logic [4:0] REG_CONFIG  = 5'd16;

   localparam logic [31:0] STATUS_RESET = 32'h10000000;

   logic [31:0] count_reg, count_next;
   logic [31:0] compare_reg, compare_next;
   logic [31:0] status_reg, status_next;
   logic [31:0] cause_reg, cause_next;
   logic [31:0] epc_reg, epc_next;
   logic        timer_int_reg, timer_int_next;

   logic        exc_valid;
   logic        exc_eret;
   logic [4:0]  exc_code;

   always_comb begin
      exc_valid = 1'b0;
      exc_eret  = 1'b0;
      exc_code  = 5'd0;
      case (excepttype_i)
         32'h0000_0001: begin exc_valid = 1'b1; exc_code = 5'd0;  end
         32'h0000_0008: begin exc_valid = 1'b1; exc_code = 5'd8;  end
         32'h0000_000a: begin exc_valid = 1'b1; exc_code = 5'd10; end
         32'h0000_000c: begin exc_valid = 1'b1; exc_code = 5'd12; end
         32'h0000_000d: begin exc_valid = 1'b1; exc_code = 5'd13; end
         32'h0000_000e: exc_eret = 1'b1;
         default: ;
      endcase
   end

   // Write lands first; interrupt latch and exception fields then override.
   always_comb begin
      count_next     = count_reg + 32'd1;
      compare_next   = compare_reg;
      status_next    = status_reg;
      cause_next     = cause_reg;
      epc_next       = epc_reg;
      timer_int_next = timer_int_reg |
                       ((compare_reg != 32'd0) && (count_reg == compare_reg));

      if (we_i) begin
         case (waddr_i)
            REG_COUNT:   count_next = data_i;
            REG_COMPARE: begin
               compare_next   = data_i;
               timer_int_next = 1'b0;
            end
            REG_STATUS:  status_next = data_i;
            REG_EPC:     epc_next = data_i;
            REG_CAUSE: begin
               cause_next[9:8]   = data_i[9:8];
               cause_next[23:22] = data_i[23:22];
            end
            default: ;
         endcase
      end

      cause_next[15:10] = int_i;

      if (exc_valid) begin
         // A nested exception (EXL already set) keeps the original EPC and BD.
         if (!status_reg[1]) begin
            if (is_in_delayslot_i) begin
               epc_next      = current_inst_addr_i - 32'd4;
               cause_next[31] = 1'b1;
            end else begin
               epc_next      = current_inst_addr_i;
               cause_next[31] = 1'b0;
            end
         end
         status_next[1]  = 1'b1;
         cause_next[6:2] = exc_code;
      end else if (exc_eret) begin
         status_next[1] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_reg     <= 32'd0;
         compare_reg   <= 32'd0;
         status_reg    <= STATUS_RESET;
         cause_reg     <= 32'd0;
         epc_reg       <= 32'd0;
         timer_int_reg <= 1'b0;
      end else begin
         count_reg     <= count_next;
         compare_reg   <= compare_next;
         status_reg    <= status_next;
         cause_reg     <= cause_next;
         epc_reg       <= epc_next;
         timer_int_reg <= timer_int_next;
      end
   end

   always_comb begin
      data_o = 32'd0;
      case (raddr_i)
         REG_COUNT:   data_o = count_reg;
         REG_COMPARE: data_o = compare_reg;
         REG_STATUS:  data_o = status_reg;
         REG_CAUSE:   data_o = cause_reg;
         REG_EPC:     data_o = epc_reg;
         REG_PRID:    data_o = PRID_VALUE;
         REG_CONFIG:  data_o = CONFIG_VALUE;
         default:     data_o = 32'd0;
      endcase
   end

   assign count_o     = count_reg;
   assign compare_o   = compare_reg;
   assign status_o    = status_reg;
   assign cause_o     = cause_reg;
   assign epc_o       = epc_reg;
   assign config_o    = CONFIG_VALUE;
   assign prid_o      = PRID_VALUE;
   assign timer_int_o = timer_int_reg;

endmodule

// File: tb/tb_cp0_reg.sv
// Self-checking bench for cp0_reg: vector table with scoreboard queue, plus
// hand-written reset, timer and Count wrap sequences.
module tb_cp0_reg;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [4:0]  raddr;
   logic [5:0]  intr;
   logic [31:0] exc;
   logic [31:0] pc;
   logic        ds;
   logic [31:0] data_o, count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o;
   logic        timer_int_o;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   cp0_reg dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .we_i                (we),
      .waddr_i             (waddr),
      .data_i              (wdata),
      .raddr_i             (raddr),
      .int_i               (intr),
      .excepttype_i        (exc),
      .current_inst_addr_i (pc),
      .is_in_delayslot_i   (ds),
      .data_o              (data_o),
      .count_o             (count_o),
      .compare_o           (compare_o),
      .status_o            (status_o),
      .cause_o             (cause_o),
      .epc_o               (epc_o),
      .config_o            (config_o),
      .prid_o              (prid_o),
      .timer_int_o         (timer_int_o)
   );

   typedef struct {
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] data;
      logic [4:0]  raddr;
      logic [5:0]  intr;
      logic [31:0] exc;
      logic [31:0] pc;
      logic        ds;
      logic [31:0] es;
      logic [31:0] ec;
      logic [31:0] ee;
      logic [31:0] erd;
   } vec_t;

   typedef struct {
      int          idx;
      logic [31:0] es;
      logic [31:0] ec;
      logic [31:0] ee;
      logic [31:0] erd;
   } exp_t;

   localparam int NV = 18;
   vec_t vecs [NV];
   exp_t sb [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, act, exp_v);
      end else begin
         $display("ok   %s = %h", name, act);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we    = 1'b0;
      waddr = 5'd0;
      wdata = 32'd0;
      intr  = 6'd0;
      exc   = 32'd0;
      pc    = 32'd0;
      ds    = 1'b0;
   endtask

   initial begin
      exp_t e;
      int   k5;
      int   kt;
      int   n;

      vecs[0]  = '{1'b1, 5'd12, 32'h0,        5'd12, 6'h00, 32'h00, 32'h0,        1'b0, 32'h0,     32'h0,        32'h0,        32'h0};
      vecs[1]  = '{1'b1, 5'd14, 32'h12345678, 5'd14, 6'h00, 32'h00, 32'h0,        1'b0, 32'h0,     32'h0,        32'h12345678, 32'h12345678};
      vecs[2]  = '{1'b1, 5'd13, 32'hFFFFFFFF, 5'd13, 6'h05, 32'h00, 32'h0,        1'b0, 32'h0,     32'h00C01700, 32'h12345678, 32'h00C01700};
      vecs[3]  = '{1'b0, 5'd0,  32'h0,        5'd13, 6'h00, 32'h00, 32'h0,        1'b0, 32'h0,     32'h00C00300, 32'h12345678, 32'h00C00300};
      vecs[4]  = '{1'b1, 5'd13, 32'h0,        5'd13, 6'h00, 32'h00, 32'h0,        1'b0, 32'h0,     32'h0,        32'h12345678, 32'h0};
      vecs[5]  = '{1'b0, 5'd0,  32'h0,        5'd14, 6'h00, 32'h08, 32'h80001004, 1'b1, 32'h2,     32'h80000020, 32'h80001000, 32'h80001000};
      vecs[6]  = '{1'b0, 5'd0,  32'h0,        5'd13, 6'h00, 32'h0c, 32'h80002000, 1'b0, 32'h2,     32'h80000030, 32'h80001000, 32'h80000030};
      vecs[7]  = '{1'b0, 5'd0,  32'h0,        5'd12, 6'h00, 32'h0e, 32'h0,        1'b0, 32'h0,     32'h80000030, 32'h80001000, 32'h0};
      vecs[8]  = '{1'b0, 5'd0,  32'h0,        5'd14, 6'h00, 32'h0d, 32'h80003000, 1'b0, 32'h2,     32'h00000034, 32'h80003000, 32'h80003000};
      vecs[9]  = '{1'b0, 5'd0,  32'h0,        5'd12, 6'h00, 32'h0e, 32'h0,        1'b0, 32'h0,     32'h00000034, 32'h80003000, 32'h0};
      vecs[10] = '{1'b1, 5'd12, 32'h0000FF00, 5'd12, 6'h00, 32'h0c, 32'h80004000, 1'b0, 32'hFF02,  32'h00000030, 32'h80004000, 32'h0000FF02};
      vecs[11] = '{1'b0, 5'd0,  32'h0,        5'd13, 6'h00, 32'h05, 32'h80009000, 1'b1, 32'hFF02,  32'h00000030, 32'h80004000, 32'h00000030};
      vecs[12] = '{1'b0, 5'd0,  32'h0,        5'd12, 6'h00, 32'h0e, 32'h0,        1'b0, 32'hFF00,  32'h00000030, 32'h80004000, 32'h0000FF00};
      vecs[13] = '{1'b1, 5'd15, 32'h0,        5'd15, 6'h00, 32'h00, 32'h0,        1'b0, 32'hFF00,  32'h00000030, 32'h80004000, 32'h004c0102};
      vecs[14] = '{1'b1, 5'd16, 32'h0,        5'd16, 6'h00, 32'h00, 32'h0,        1'b0, 32'hFF00,  32'h00000030, 32'h80004000, 32'h00008000};
      vecs[15] = '{1'b1, 5'd5,  32'hFFFFFFFF, 5'd5,  6'h00, 32'h00, 32'h0,        1'b0, 32'hFF00,  32'h00000030, 32'h80004000, 32'h0};
      vecs[16] = '{1'b0, 5'd0,  32'h0,        5'd13, 6'h00, 32'h01, 32'h80005000, 1'b1, 32'hFF02,  32'h80000000, 32'h80004FFC, 32'h80000000};
      vecs[17] = '{1'b0, 5'd0,  32'h0,        5'd13, 6'h3f, 32'h0e, 32'h0,        1'b0, 32'hFF00,  32'h8000FC00, 32'h80004FFC, 32'h8000FC00};

      // Reset with stuck inputs, including an exception in flight.
      rst_n = 1'b0;
      raddr = 5'd12;
      we    = 1'b1;
      waddr = 5'd12;
      wdata = 32'hFFFFFFFF;
      intr  = 6'h3f;
      exc   = 32'h08;
      pc    = 32'h80001004;
      ds    = 1'b1;
      repeat (3) step();
      chk("rst.status",  status_o,  32'h10000000);
      chk("rst.config",  config_o,  32'h00008000);
      chk("rst.prid",    prid_o,    32'h004c0102);
      chk("rst.count",   count_o,   32'h0);
      chk("rst.compare", compare_o, 32'h0);
      chk("rst.cause",   cause_o,   32'h0);
      chk("rst.epc",     epc_o,     32'h0);
      chk("rst.timer",   {31'd0, timer_int_o}, 32'h0);
      chk("rst.read",    data_o,    32'h10000000);

      idle();
      rst_n = 1'b1;
      step();
      step();
      chk("post_rst.count", count_o, 32'd2);
      chk("post_rst.timer_cmp0", {31'd0, timer_int_o}, 32'h0);

      for (int i = 0; i < NV; i++) begin
         we    = vecs[i].we;
         waddr = vecs[i].waddr;
         wdata = vecs[i].data;
         raddr = vecs[i].raddr;
         intr  = vecs[i].intr;
         exc   = vecs[i].exc;
         pc    = vecs[i].pc;
         ds    = vecs[i].ds;
         sb.push_back('{i, vecs[i].es, vecs[i].ec, vecs[i].ee, vecs[i].erd});
         step();
         e = sb.pop_front();
         chk($sformatf("row%0d.status", e.idx), status_o, e.es);
         chk($sformatf("row%0d.cause",  e.idx), cause_o,  e.ec);
         chk($sformatf("row%0d.epc",    e.idx), epc_o,    e.ee);
         chk($sformatf("row%0d.read",   e.idx), data_o,   e.erd);
      end
      idle();

      // Timer: Compare=5 written while Count reads 0.
      we = 1'b1; waddr = 5'd9; wdata = 32'd0;
      step();
      chk("tmr.count0", count_o, 32'd0);
      waddr = 5'd11; wdata = 32'd5;
      step();
      idle();
      chk("tmr.compare5", compare_o, 32'd5);
      chk("tmr.count1", count_o, 32'd1);
      k5 = -1;
      kt = -1;
      for (int c = 0; c < 30 && kt < 0; c++) begin
         step();
         if (count_o == 32'd5) k5 = c;
         if (timer_int_o) kt = c;
      end
      chk("tmr.count_hit5_cycle", k5, 32'd3);
      chk("tmr.rise_cycle", kt, 32'd4);
      step();
      chk("tmr.sticky", {31'd0, timer_int_o}, 32'h1);

      we = 1'b1; waddr = 5'd11; wdata = 32'd20;
      step();
      idle();
      chk("tmr.fall", {31'd0, timer_int_o}, 32'h0);
      chk("tmr.compare20", compare_o, 32'd20);

      // Compare write in the very cycle Count == Compare: clear must win.
      n = 0;
      while (count_o != 32'd20 && n < 40) begin
         step();
         n++;
      end
      chk("tmr.reach20", count_o, 32'd20);
      we = 1'b1; waddr = 5'd11; wdata = 32'd100;
      step();
      idle();
      chk("tmr.clear_wins", {31'd0, timer_int_o}, 32'h0);
      step();
      chk("tmr.clear_holds", {31'd0, timer_int_o}, 32'h0);

      // Count write wins over increment, then wraps.
      raddr = 5'd9;
      we = 1'b1; waddr = 5'd9; wdata = 32'hFFFFFFFF;
      step();
      idle();
      chk("wrap.ffff", data_o, 32'hFFFFFFFF);
      step();
      chk("wrap.zero", count_o, 32'h0);
      step();
      chk("wrap.one", data_o, 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
